tensor_core_instruction_arbiter: RTL and testbench
==================================================

TENSOR_CORE_INSTRUCTION_ARBITER -- requirements
Module: tensor_core_instruction_arbiter

Interface
REQ-001 Parameter INSTR_WIDTH, default 16, tensor core instruction word width.
REQ-002 Parameter BURST_BEATS, default 5, data beats that follow a BURST opcode word.
REQ-003 clock_in  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_in  input  1  reset, synchronous and active-low.
REQ-005 req0_valid / req1_valid  input  1 each  requester has an instruction word.
REQ-006 req0_instruction / req1_instruction  input  INSTR_WIDTH each  requester instruction word; opcode in bits [1:0].
REQ-007 req0_ready / req1_ready  output  1 each  word accepted this cycle when ready and valid are both high.
REQ-008 out_valid  output  1  registered word is pending for the tensor core.
REQ-009 out_instruction  output  INSTR_WIDTH  registered word to the tensor core.
REQ-010 out_ready  input  1  tensor core consumes the pending word.
REQ-011 abort_in  input  1  drops any burst lock.
REQ-012 burst_locked  output  1  high while in state LOCK.
REQ-013 lock_owner  output  1  requester holding the lock; 0 when not locked.

Function
REQ-014 FSM states: ARB (select per word) and LOCK (grant held for one requester).
REQ-015 A single-entry output register is loadable when out_valid is 0, or when out_valid and out_ready are both 1.
REQ-016 Only the granted requester sees ready high, and only while the register is loadable; the other requester's ready is 0.
REQ-017 Latency is 1 cycle: an accepted word appears on out_instruction with out_valid high on the next cycle.
REQ-018 Full throughput with out_ready held at 1: one word per cycle.
REQ-019 ARB grant:
  - only one requester valid -> that requester is granted;
  - both valid -> the requester named by the rr_ptr register is granted;
  - neither valid -> no grant.
REQ-020 A non-BURST word (opcode != 2'b10) accepted in ARB sets rr_ptr to the other requester.
REQ-021 A word with opcode 2'b10 accepted in ARB moves the FSM to LOCK, records the owner and sets beat_count to 0.
REQ-022 In LOCK only the owner is granted; opcodes of data beats are not decoded.
REQ-023 In LOCK, each accepted beat increments beat_count; the beat accepted at beat_count == BURST_BEATS-1 returns the FSM to ARB and sets rr_ptr to the non-owner.
REQ-024 Owner valid low while in LOCK -> stall; the lock is held for an unlimited time.
REQ-025 abort_in high -> FSM goes to ARB and beat_count clears next cycle, with no accept that cycle; a pending out_instruction is kept.
REQ-026 RESET opcode (2'b11) words pass through unchanged and are arbitrated like other non-BURST words.
REQ-027 beat_count width is $clog2(BURST_BEATS); it never wraps past BURST_BEATS-1.

Reset
REQ-028 reset_in low at a clock edge sets: FSM to ARB, rr_ptr to 0, beat_count to 0, out_valid to 0, out_instruction to 0, burst_locked to 0, lock_owner to 0.
REQ-029 Reset during LOCK discards the burst; partially delivered beats are not replayed.
REQ-030 req0_ready and req1_ready are 0 in any cycle where reset_in is low.

Configuration
REQ-031 With TENSOR_CORE_ARB_PERF_COUNTERS_EN defined:
  - outputs grant_count0 and grant_count1 (32 bits each) count accepted words per requester;
  - the counters wrap at 2^32 and clear on reset.
REQ-032 Without TENSOR_CORE_ARB_PERF_COUNTERS_EN: those ports and their registers are absent; behaviour is otherwise identical.

Structure
REQ-033 Shared package tensor_core_pkg holds:
  - opcode constants NOP 2'b00, OPERATE 2'b01, BURST 2'b10, RESET 2'b11;
  - the arb_state_t enum {ARB, LOCK};
  - the INSTR_WIDTH default.
REQ-034 One sub-module, tensor_core_output_register, implements the valid/ready single-entry register; all other logic is in the top module.

Verification
REQ-035 Both requesters valid every cycle, all NOPs, out_ready=1 -> grants alternate 0,1,0,1; one word out per cycle.
REQ-036 req0 sends BURST word 0x0006 then beats 0xAAA1..0xAAA5 while req1 is always valid:
  - no req1 word is accepted until 0xAAA5 is accepted;
  - req1 is granted next.
REQ-037 out_ready=0 for 3 cycles with a word pending -> out_instruction stable, both ready=0, no words lost.
REQ-038 abort_in pulsed after beat 2 of a req1 burst -> burst_locked=0 next cycle; req0 is grantable.
REQ-039 reset_in low mid-burst -> all outputs take their reset values next cycle; the next BURST word restarts beat_count at 0.
REQ-040 With TENSOR_CORE_ARB_PERF_COUNTERS_EN defined, after 10 req0 and 7 req1 accepted words -> grant_count0=10, grant_count1=7.

Source files
------------

// File: rtl/tensor_core_pkg.sv
// Shared definitions for the tensor core instruction arbiter:
// opcode encodings, arbiter FSM state type and the default word width.
package tensor_core_pkg;

   localparam int INSTR_WIDTH_DEFAULT = 16;

   localparam logic [1:0] NOP     = 2'b00;
   localparam logic [1:0] OPERATE = 2'b01;
   localparam logic [1:0] BURST   = 2'b10;
   localparam logic [1:0] RESET   = 2'b11;

   typedef enum logic [0:0] {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   // True when the opcode field of a word starts a locked burst
   function automatic logic is_burst(input logic [1:0] opcode);
      return opcode == BURST;
   endfunction

endpackage

// File: rtl/tensor_core_output_register.sv
// Single-entry valid/ready output register. Accepts a new word whenever it is
// empty or its current word is being consumed in the same cycle.
module tensor_core_output_register
   import tensor_core_pkg::*;
#(
   parameter int INSTR_WIDTH = INSTR_WIDTH_DEFAULT
) (
   input  logic                   clock_in,
   input  logic                   reset_in,
   input  logic                   load_valid,
   input  logic [INSTR_WIDTH-1:0] load_instruction,
   input  logic                   out_ready,
   output logic                   loadable,
   output logic                   out_valid,
   output logic [INSTR_WIDTH-1:0] out_instruction
);

   logic                   vld_p1;
   logic [INSTR_WIDTH-1:0] instr_p1;

   assign loadable        = !vld_p1 || out_ready;
   assign out_valid       = vld_p1;
   assign out_instruction = instr_p1;

   // Output stage: capture the accepted word, hold it until consumed
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         vld_p1   <= 1'b0;
         instr_p1 <= '0;
      end else if (loadable) begin
         vld_p1 <= load_valid;
         if (load_valid) begin
            instr_p1 <= load_instruction;
         end
      end
   end

endmodule

// File: rtl/tensor_core_instruction_arbiter.sv
// Two-requester instruction arbiter for the tensor core. Round-robin per word,
// with BURST opcodes locking the grant to one requester for BURST_BEATS beats.
// Optional feature: define TENSOR_CORE_ARB_PERF_COUNTERS_EN to add per-requester
// 32-bit accepted-word counters (grant_count0 / grant_count1).
module tensor_core_instruction_arbiter
   import tensor_core_pkg::*;
#(
   parameter int INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
   parameter int BURST_BEATS = 5
) (
   input  logic                   clock_in,
   input  logic                   reset_in,
   input  logic                   req0_valid,
   input  logic [INSTR_WIDTH-1:0] req0_instruction,
   output logic                   req0_ready,
   input  logic                   req1_valid,
   input  logic [INSTR_WIDTH-1:0] req1_instruction,
   output logic                   req1_ready,
   output logic                   out_valid,
   output logic [INSTR_WIDTH-1:0] out_instruction,
   input  logic                   out_ready,
   input  logic                   abort_in,
   output logic                   burst_locked,
   output logic                   lock_owner
`ifdef TENSOR_CORE_ARB_PERF_COUNTERS_EN
   ,
   output logic [31:0]            grant_count0,
   output logic [31:0]            grant_count1
`endif
);

   // A single-beat burst still needs a 1-bit counter to be well formed
   localparam int BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

   arb_state_t             state;
   logic                   rr_ptr;
   logic                   owner;
   logic [BEAT_W-1:0]      beat_count;

   logic                   grant_valid;
   logic                   grant_id;
   logic                   loadable;
   logic                   accept;
   logic [INSTR_WIDTH-1:0] accept_instruction;

   // Grant selection: owner only while locked, otherwise round-robin on contention
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      if (state == LOCK) begin
         grant_id    = owner;
         grant_valid = owner ? req1_valid : req0_valid;
      end else if (req0_valid && req1_valid) begin
         grant_valid = 1'b1;
         grant_id    = rr_ptr;
      end else if (req0_valid) begin
         grant_valid = 1'b1;
         grant_id    = 1'b0;
      end else if (req1_valid) begin
         grant_valid = 1'b1;
         grant_id    = 1'b1;
      end
   end

   // An abort cycle is a dead cycle: nothing is accepted while the lock is dropped
   assign accept             = reset_in && !abort_in && loadable && grant_valid;
   assign req0_ready         = accept && !grant_id;
   assign req1_ready         = accept && grant_id;
   assign accept_instruction = grant_id ? req1_instruction : req0_instruction;

   assign burst_locked = (state == LOCK);
   assign lock_owner   = (state == LOCK) ? owner : 1'b0;

   // FSM, round-robin pointer, lock owner and beat counter
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         state      <= ARB;
         rr_ptr     <= 1'b0;
         owner      <= 1'b0;
         beat_count <= '0;
      end else if (abort_in) begin
         state      <= ARB;
         beat_count <= '0;
      end else if (accept) begin
         if (state == ARB) begin
            if (is_burst(accept_instruction[1:0])) begin
               state      <= LOCK;
               owner      <= grant_id;
               beat_count <= '0;
            end else begin
               rr_ptr <= ~grant_id;
            end
         end else if (beat_count == LAST_BEAT) begin
            state      <= ARB;
            rr_ptr     <= ~owner;
            beat_count <= '0;
         end else begin
            beat_count <= beat_count + BEAT_W'(1);
         end
      end
   end

   tensor_core_output_register #(
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_out_reg (
      .clock_in         (clock_in),
      .reset_in         (reset_in),
      .load_valid       (accept),
      .load_instruction (accept_instruction),
      .out_ready        (out_ready),
      .loadable         (loadable),
      .out_valid        (out_valid),
      .out_instruction  (out_instruction)
   );

`ifdef TENSOR_CORE_ARB_PERF_COUNTERS_EN
   // Accepted-word counters per requester, free-running with natural wrap
   always_ff @(posedge clock_in) begin
      if (!reset_in) begin
         grant_count0 <= '0;
         grant_count1 <= '0;
      end else begin
         if (req0_ready) grant_count0 <= grant_count0 + 32'd1;
         if (req1_ready) grant_count1 <= grant_count1 + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tensor_core_instruction_arbiter.sv
// Scoreboard bench for tensor_core_instruction_arbiter: directed vectors push
// expected output words, a negedge monitor pops them as the DUT delivers.
module tb_tensor_core_instruction_arbiter;

   logic        clock_in = 1'b0;
   logic        reset_in = 1'b0;
   logic        req0_valid = 1'b0;
   logic [15:0] req0_instruction = '0;
   logic        req0_ready;
   logic        req1_valid = 1'b0;
   logic [15:0] req1_instruction = '0;
   logic        req1_ready;
   logic        out_valid;
   logic [15:0] out_instruction;
   logic        out_ready = 1'b0;
   logic        abort_in = 1'b0;
   logic        burst_locked;
   logic        lock_owner;
`ifdef TENSOR_CORE_ARB_PERF_COUNTERS_EN
   logic [31:0] grant_count0;
   logic [31:0] grant_count1;
`endif

   int          checks = 0;
   int          failures = 0;
   int          cnt0 = 0;
   int          cnt1 = 0;
   logic [15:0] exp_q[$];

   always #5 clock_in = ~clock_in;

   tensor_core_instruction_arbiter #(
      .INSTR_WIDTH (16),
      .BURST_BEATS (5)
   ) dut (
      .clock_in         (clock_in),
      .reset_in         (reset_in),
      .req0_valid       (req0_valid),
      .req0_instruction (req0_instruction),
      .req0_ready       (req0_ready),
      .req1_valid       (req1_valid),
      .req1_instruction (req1_instruction),
      .req1_ready       (req1_ready),
      .out_valid        (out_valid),
      .out_instruction  (out_instruction),
      .out_ready        (out_ready),
      .abort_in         (abort_in),
      .burst_locked     (burst_locked),
      .lock_owner       (lock_owner)
`ifdef TENSOR_CORE_ARB_PERF_COUNTERS_EN
      ,
      .grant_count0     (grant_count0),
      .grant_count1     (grant_count1)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // One cycle: drive inputs, check hand-computed readies, queue expected words
   task automatic step(input logic v0, input logic [15:0] i0,
                       input logic v1, input logic [15:0] i1,
                       input logic ordy, input logic ab,
                       input logic er0, input logic er1);
      req0_valid = v0; req0_instruction = i0;
      req1_valid = v1; req1_instruction = i1;
      out_ready = ordy; abort_in = ab;
      #1;
      check("req0_ready", {31'd0, req0_ready}, {31'd0, er0});
      check("req1_ready", {31'd0, req1_ready}, {31'd0, er1});
      if (er0 && v0) begin exp_q.push_back(i0); cnt0++; end
      if (er1 && v1) begin exp_q.push_back(i1); cnt1++; end
      @(posedge clock_in); #1;
   endtask

   task automatic idle();
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: every word consumed by the tensor core must match the queue head
   always @(negedge clock_in) begin
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_word actual=%h required=none", out_instruction);
         end else begin
            check("out_word", {16'd0, out_instruction}, {16'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(posedge clock_in); #1;
      // Reset: readies held low even with requests present
      step(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.delete(); cnt0 = 0; cnt1 = 0;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_instr", {16'd0, out_instruction}, 32'd0);
      check("rst_locked", {31'd0, burst_locked}, 32'd0);
      check("rst_owner", {31'd0, lock_owner}, 32'd0);
      reset_in = 1'b1;

      // Alternating grants, one word per cycle; req0 words carry RESET opcode
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 16'(16'h1003 + k * 16), 1'b1, 16'(16'h2000 + k * 16),
              1'b1, 1'b0, (k % 2 == 0), (k % 2 == 1));
         check("rr_out_valid", {31'd0, out_valid}, 32'd1);
      end
      idle();
      check("q_empty_rr", 32'(exp_q.size()), 32'd0);

      // req0 burst: req1 locked out until the fifth beat
      step(1'b1, 16'h0006, 1'b1, 16'h0201, 1'b1, 1'b0, 1'b1, 1'b0);
      check("burst0_locked", {31'd0, burst_locked}, 32'd1);
      check("burst0_owner", {31'd0, lock_owner}, 32'd0);
      for (int k = 1; k <= 5; k++) begin
         step(1'b1, 16'(16'hAAA0 + k), 1'b1, 16'h0201, 1'b1, 1'b0, 1'b1, 1'b0);
         check("burst0_locked_beat", {31'd0, burst_locked}, (k < 5) ? 32'd1 : 32'd0);
      end
      step(1'b1, 16'h0300, 1'b1, 16'h0204, 1'b1, 1'b0, 1'b0, 1'b1);
      idle();

      // Backpressure: pending word held, both readies low for 3 cycles
      step(1'b1, 16'h0310, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 16'h0320, 1'b1, 16'h0220, 1'b0, 1'b0, 1'b0, 1'b0);
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_instr", {16'd0, out_instruction}, 32'h0310);
      end
      step(1'b1, 16'h0320, 1'b1, 16'h0220, 1'b1, 1'b0, 1'b0, 1'b1);
      idle();

      // req1 burst aborted after beat 2 with the beat still pending
      step(1'b0, 16'h0, 1'b1, 16'h0012, 1'b1, 1'b0, 1'b0, 1'b1);
      check("burst1_owner", {31'd0, lock_owner}, 32'd1);
      check("burst1_locked", {31'd0, burst_locked}, 32'd1);
      step(1'b1, 16'h0400, 1'b1, 16'hBBB1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'h0400, 1'b1, 16'hBBB2, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'h0400, 1'b1, 16'hBBB3, 1'b0, 1'b1, 1'b0, 1'b0);
      check("abort_locked", {31'd0, burst_locked}, 32'd0);
      check("abort_owner", {31'd0, lock_owner}, 32'd0);
      check("abort_keep_valid", {31'd0, out_valid}, 32'd1);
      check("abort_keep_instr", {16'd0, out_instruction}, 32'hBBB2);
      step(1'b1, 16'h0401, 1'b1, 16'hBBB3, 1'b1, 1'b0, 1'b1, 1'b0);
      idle();

      // Reset in the middle of a req1 burst
      step(1'b0, 16'h0, 1'b1, 16'h0022, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 16'h0, 1'b1, 16'hCCC1, 1'b1, 1'b0, 1'b0, 1'b1);
      reset_in = 1'b0;
      step(1'b0, 16'h0, 1'b1, 16'hCCC2, 1'b1, 1'b0, 1'b0, 1'b0);
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_instr", {16'd0, out_instruction}, 32'd0);
      check("mid_rst_locked", {31'd0, burst_locked}, 32'd0);
      check("mid_rst_owner", {31'd0, lock_owner}, 32'd0);
      cnt0 = 0; cnt1 = 0;
`ifdef TENSOR_CORE_ARB_PERF_COUNTERS_EN
      check("rst_count0", grant_count0, 32'd0);
      check("rst_count1", grant_count1, 32'd0);
`endif
      reset_in = 1'b1;
      // Fresh burst after reset must run the full five beats
      step(1'b1, 16'h0036, 1'b1, 16'h0230, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         step(1'b1, 16'(16'hDDD0 + k), 1'b1, 16'h0230, 1'b1, 1'b0, 1'b1, 1'b0);
         check("post_rst_locked", {31'd0, burst_locked}, (k < 5) ? 32'd1 : 32'd0);
      end
      step(1'b1, 16'h0040, 1'b1, 16'h0230, 1'b1, 1'b0, 1'b0, 1'b1);
      idle();
      idle();
      check("q_empty_end", 32'(exp_q.size()), 32'd0);
`ifdef TENSOR_CORE_ARB_PERF_COUNTERS_EN
      check("grant_count0", grant_count0, 32'(cnt0));
      check("grant_count1", grant_count1, 32'(cnt1));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
